// File: rtl/program_loader.sv
// program_loader: loads a checksummed byte-stream program image into instruction memory, holding the CPU in clear until it verifies
module program_loader #(
  parameter int MAX_WORDS = 256,
  parameter int COUNT_WIDTH = 9
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   reload,
  output logic                   imem_write,
  output logic [31:0]            imem_address,
  output logic [31:0]            imem_data,
  output logic                   cpu_clear,
  output logic                   load_done,
  output logic                   load_error,
  output logic [COUNT_WIDTH-1:0] words_loaded
);
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERROR} state_t;
  state_t state, state_nx;
  logic [15:0] count;
  logic [1:0] byte_idx;
  logic [23:0] word_buf;
  logic [7:0] csum;
  logic take, word_end, last_word, restart;
  logic [15:0] hdr;
  assign in_ready = state != RUN && state != ERROR;
  assign take = in_valid && in_ready;
  assign hdr = {in_data, count[7:0]};
  assign word_end = take && state == DATA && byte_idx == 2'd3;
  assign last_word = 16'(words_loaded) + 16'd1 == count;
  assign restart = reload && !in_ready;
  always_comb begin
    state_nx = state;
    case (state)
      LEN0:    state_nx = take ? LEN1 : LEN0;
      LEN1:    state_nx = !take ? LEN1 : hdr > 16'(MAX_WORDS) ? ERROR : hdr == 16'd0 ? CSUM : DATA;
      DATA:    state_nx = word_end && last_word ? CSUM : DATA;
      CSUM:    state_nx = !take ? CSUM : in_data == csum ? RUN : ERROR;
      default: state_nx = restart ? LEN0 : state;
    endcase
  end
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= LEN0;
    else state <= state_nx;
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      imem_write   <= 1'b0;
      imem_address <= '0;
      imem_data    <= '0;
      cpu_clear    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
    end else begin
      imem_write <= word_end;
      cpu_clear  <= state_nx != RUN;
      load_done  <= state_nx == RUN;
      load_error <= state_nx == ERROR;
      if (take && state == LEN0) count[7:0] <= in_data;
      if (take && state == LEN1) count[15:8] <= in_data;
      if (take && state == DATA) begin
        byte_idx <= byte_idx + 2'd1;
        csum     <= csum ^ in_data;
        word_buf <= {in_data, word_buf[23:8]};
      end
      if (word_end) begin
        imem_data    <= {in_data, word_buf};
        imem_address <= {{(30 - COUNT_WIDTH){1'b0}}, words_loaded, 2'b00};
        words_loaded <= words_loaded + COUNT_WIDTH'(1);
      end
      if (restart) begin
        words_loaded <= '0;
        count        <= '0;
        byte_idx     <= '0;
        csum         <= '0;
      end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed-vector self-checking bench for program_loader
module tb_program_loader;
  logic clock = 1'b0, clear = 1'b1, in_valid = 1'b0, reload = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, imem_write, cpu_clear, load_done, load_error;
  logic [31:0] imem_address, imem_data;
  logic [8:0] words_loaded;
  int tests = 0, fails = 0;
  logic [31:0] wa[$], wd[$];
  logic [7:0] frame [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'h2A, 8'h00, 8'h09, 8'h20, 8'h38};

  program_loader dut (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .imem_write(imem_write), .imem_address(imem_address), .imem_data(imem_data),
    .cpu_clear(cpu_clear), .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (imem_write) begin
      wa.push_back(imem_address);
      wd.push_back(imem_data);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap, input logic exp_w);
    repeat (gap) @(posedge clock);
    #1 in_valid = 1'b1;
    in_data = b;
    @(posedge clock);
    #1 in_valid = 1'b0;
    check("write_strobe", 32'(imem_write), 32'(exp_w));
  endtask

  task automatic send_frame(input logic [7:0] last, input int gap);
    for (int i = 0; i < 10; i++) send(frame[i], gap, i == 5 || i == 9);
    send(last, gap, 1'b0);
  endtask

  task automatic pulse_reload();
    #1 reload = 1'b1;
    @(posedge clock);
    #1 reload = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic check_writes();
    check("write_count", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("addr0", wa[0], 32'h0);
      check("data0", wd[0], 32'h20080013);
      check("addr1", wa[1], 32'h4);
      check("data1", wd[1], 32'h2009002A);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    check("rst_cpu_clear", 32'(cpu_clear), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_write", 32'(imem_write), 32'd0);

    send_frame(8'h38, 0);
    check("good_cpu_clear", 32'(cpu_clear), 32'd0);
    check("good_done", 32'(load_done), 32'd1);
    check("good_words", 32'(words_loaded), 32'd2);
    check("good_ready", 32'(in_ready), 32'd0);
    check_writes();
    send(8'hFF, 0, 1'b0);
    check("run_ignores_input", 32'(words_loaded), 32'd2);
    check("run_still_done", 32'(load_done), 32'd1);

    pulse_reload();
    check("reload_ready", 32'(in_ready), 32'd1);
    check("reload_done", 32'(load_done), 32'd0);
    send_frame(8'h39, 0);
    check_writes();
    check("bad_error", 32'(load_error), 32'd1);
    check("bad_cpu_clear", 32'(cpu_clear), 32'd1);
    check("bad_done", 32'(load_done), 32'd0);
    check("bad_ready", 32'(in_ready), 32'd0);
    pulse_reload();
    check("bad_reload_ready", 32'(in_ready), 32'd1);
    check("bad_reload_error", 32'(load_error), 32'd0);
    check("bad_reload_words", 32'(words_loaded), 32'd0);

    send(8'h01, 0, 1'b0);
    send(8'h01, 0, 1'b0);
    check("big_error", 32'(load_error), 32'd1);
    check("big_ready", 32'(in_ready), 32'd0);
    check("big_cpu_clear", 32'(cpu_clear), 32'd1);
    repeat (3) @(posedge clock);
    check("big_no_write", 32'(wa.size()), 32'd0);

    pulse_reload();
    send(8'h00, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    check("empty_done", 32'(load_done), 32'd1);
    check("empty_cpu_clear", 32'(cpu_clear), 32'd0);
    check("empty_words", 32'(words_loaded), 32'd0);
    check("empty_no_write", 32'(wa.size()), 32'd0);
    pulse_reload();
    send(8'h00, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h01, 0, 1'b0);
    check("empty_bad_error", 32'(load_error), 32'd1);
    check("empty_bad_done", 32'(load_done), 32'd0);

    pulse_reload();
    send_frame(8'h38, 3);
    check_writes();
    check("stall_done", 32'(load_done), 32'd1);
    #2 clear = 1'b1;
    #1 check("clear_run_cpu_clear", 32'(cpu_clear), 32'd1);
    check("clear_run_done", 32'(load_done), 32'd0);
    check("clear_run_words", 32'(words_loaded), 32'd0);
    @(posedge clock);
    #1 clear = 1'b0;
    wa.delete();
    wd.delete();

    for (int i = 0; i < 5; i++) send(frame[i], 0, 1'b0);
    #2 clear = 1'b1;
    #1 check("clear_mid_cpu_clear", 32'(cpu_clear), 32'd1);
    check("clear_mid_words", 32'(words_loaded), 32'd0);
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    check("clear_mid_no_write", 32'(wa.size()), 32'd0);
    send_frame(8'h38, 0);
    check_writes();
    check("after_clear_done", 32'(load_done), 32'd1);
    check("after_clear_words", 32'(words_loaded), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
